// File: rtl/mem_dbus_if.sv
// MEM-stage data-bus master: turns one load/store into a req/ack bus transaction,
// stalls the pipeline while it is outstanding and buffers load data until the stall clears.
// Optional alignment check enabled by defining DBUS_ALIGN_CHECK_EN.
module mem_dbus_if #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic        cpu_ce,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [3:0]  cpu_sel,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        stallreq,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
`ifdef DBUS_ALIGN_CHECK_EN
    output logic        misalign_exc,
`endif
    output logic        bus_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam bit          TMO_EN   = (TIMEOUT_CYC != 0);
    localparam logic [31:0] TMO_LAST = TIMEOUT_CYC - 32'd1;

    state_e      state_q;
    logic        bus_req_q;
    logic        bus_we_q;
    logic [31:0] bus_addr_q;
    logic [3:0]  bus_sel_q;
    logic [31:0] bus_wdata_q;
    logic        bus_timeout_q;
    logic [31:0] rd_buf_q;
    logic [31:0] cnt_q;

    logic misalign;
    logic issue;
    logic timeout_hit;

`ifdef DBUS_ALIGN_CHECK_EN
    assign misalign = ((cpu_sel == 4'b1111) && (cpu_addr[1:0] != 2'b00)) ||
                      (((cpu_sel == 4'b0011) || (cpu_sel == 4'b1100)) && cpu_addr[0]);
    assign misalign_exc = (state_q == ST_IDLE) && cpu_ce && misalign;
`else
    assign misalign = 1'b0;
`endif

    assign issue       = (state_q == ST_IDLE) && cpu_ce && !flush && !misalign;
    // The counter holds the number of ack-less BUSY cycles already seen.
    assign timeout_hit = TMO_EN && (state_q == ST_BUSY) && !bus_ack && (cnt_q == TMO_LAST);

    always_comb begin
        stallreq  = issue || ((state_q == ST_BUSY) && !flush && !bus_ack && !timeout_hit);
        cpu_rdata = 32'd0;
        if ((state_q == ST_BUSY) && !flush && bus_ack && !bus_we_q) begin
            cpu_rdata = bus_rdata;
        end else if (state_q == ST_HOLD) begin
            cpu_rdata = rd_buf_q;
        end
    end

    assign bus_req     = bus_req_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_sel     = bus_sel_q;
    assign bus_wdata   = bus_wdata_q;
    assign bus_timeout = bus_timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= 32'd0;
            bus_sel_q     <= 4'd0;
            bus_wdata_q   <= 32'd0;
            bus_timeout_q <= 1'b0;
            rd_buf_q      <= 32'd0;
            cnt_q         <= 32'd0;
        end else begin
            bus_timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (issue) begin
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= cpu_we;
                        bus_addr_q  <= cpu_addr;
                        bus_sel_q   <= cpu_sel;
                        bus_wdata_q <= cpu_wdata;
                        rd_buf_q    <= 32'd0;
                        cnt_q       <= 32'd0;
                        state_q     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (flush) begin
                        bus_req_q   <= 1'b0;
                        bus_we_q    <= 1'b0;
                        bus_addr_q  <= 32'd0;
                        bus_sel_q   <= 4'd0;
                        bus_wdata_q <= 32'd0;
                        state_q     <= ST_IDLE;
                    end else if (bus_ack) begin
                        bus_req_q <= 1'b0;
                        bus_we_q  <= 1'b0;
                        bus_sel_q <= 4'd0;
                        if (!bus_we_q) begin
                            rd_buf_q <= bus_rdata;
                        end
                        state_q <= (stall != 6'd0) ? ST_HOLD : ST_IDLE;
                    end else if (timeout_hit) begin
                        bus_req_q     <= 1'b0;
                        bus_we_q      <= 1'b0;
                        bus_addr_q    <= 32'd0;
                        bus_sel_q     <= 4'd0;
                        bus_wdata_q   <= 32'd0;
                        bus_timeout_q <= 1'b1;
                        rd_buf_q      <= 32'd0;
                        state_q       <= (stall != 6'd0) ? ST_HOLD : ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                ST_HOLD: begin
                    if (stall == 6'd0) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dbus_if.sv
// Bench for mem_dbus_if: transaction-level model compared every cycle, plus
// hand-computed directed expectations and a load-data queue.
module tb_mem_dbus_if;

    localparam int TMO = 4;

    logic        clk;
    logic        rst_n;
    logic [5:0]  stall;
    logic        flush;
    logic        cpu_ce;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [3:0]  cpu_sel;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        stallreq;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_timeout;
`ifdef DBUS_ALIGN_CHECK_EN
    logic        misalign_exc;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    mem_dbus_if #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .cpu_ce(cpu_ce), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_sel(cpu_sel),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .stallreq(stallreq),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
`ifdef DBUS_ALIGN_CHECK_EN
        .misalign_exc(misalign_exc),
`endif
        .bus_timeout(bus_timeout)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // One transaction at a time: busy while waiting for ack, holding while the
    // pipeline is still stalled after completion. m_cyc numbers the BUSY cycles from 1.
    logic        m_busy, m_hold, m_req, m_we, m_tmo;
    logic [31:0] m_addr, m_wdata, m_buf;
    logic [3:0]  m_sel;
    int          m_cyc;

    function automatic logic misaligned(input logic [3:0] s, input logic [1:0] a);
        logic r;
        r = 1'b0;
`ifdef DBUS_ALIGN_CHECK_EN
        r = ((s == 4'hF) && (a != 2'b00)) || (((s == 4'h3) || (s == 4'hC)) && a[0]);
`endif
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_hold <= 1'b0; m_req <= 1'b0; m_we <= 1'b0; m_tmo <= 1'b0;
            m_addr <= '0; m_wdata <= '0; m_buf <= '0; m_sel <= '0; m_cyc <= 0;
        end else begin
            m_tmo <= 1'b0;
            if (m_busy) begin
                if (flush) begin
                    m_busy <= 1'b0; m_req <= 1'b0; m_we <= 1'b0; m_sel <= '0;
                    m_addr <= '0; m_wdata <= '0;
                end else if (bus_ack) begin
                    m_busy <= 1'b0; m_req <= 1'b0; m_we <= 1'b0; m_sel <= '0;
                    if (!m_we) m_buf <= bus_rdata;
                    m_hold <= (stall != 6'd0);
                end else if (m_cyc == TMO) begin
                    m_busy <= 1'b0; m_req <= 1'b0; m_we <= 1'b0; m_sel <= '0;
                    m_addr <= '0; m_wdata <= '0; m_buf <= '0; m_tmo <= 1'b1;
                    m_hold <= (stall != 6'd0);
                end else begin
                    m_cyc <= m_cyc + 1;
                end
            end else if (m_hold) begin
                if (stall == 6'd0) m_hold <= 1'b0;
            end else if (cpu_ce && !flush && !misaligned(cpu_sel, cpu_addr[1:0])) begin
                m_busy <= 1'b1; m_cyc <= 1; m_req <= 1'b1; m_we <= cpu_we;
                m_addr <= cpu_addr; m_sel <= cpu_sel; m_wdata <= cpu_wdata; m_buf <= '0;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic        e_idle, e_issue, e_end, e_stall, e_load_done;
        logic [31:0] e_rdata;
        if (rst_n) begin
            e_idle      = !m_busy && !m_hold;
            e_issue     = e_idle && cpu_ce && !flush && !misaligned(cpu_sel, cpu_addr[1:0]);
            e_end       = m_busy && (flush || bus_ack || (m_cyc == TMO));
            e_stall     = e_issue || (m_busy && !e_end);
            e_load_done = m_busy && !flush && bus_ack && !m_we;
            e_rdata     = e_load_done ? bus_rdata : (m_hold ? m_buf : 32'd0);
            check1("stallreq", stallreq, e_stall);
            check32("cpu_rdata", cpu_rdata, e_rdata);
            check1("bus_req", bus_req, m_req);
            check1("bus_we", bus_we, m_we);
            check32("bus_sel", 32'(bus_sel), 32'(m_sel));
            check1("bus_timeout", bus_timeout, m_tmo);
            if (m_req) begin
                check32("bus_addr", bus_addr, m_addr);
                check32("bus_wdata", bus_wdata, m_wdata);
            end
`ifdef DBUS_ALIGN_CHECK_EN
            check1("misalign_exc", misalign_exc,
                   e_idle && cpu_ce && misaligned(cpu_sel, cpu_addr[1:0]));
`endif
            if (e_load_done && exp_q.size() > 0) begin
                check32("load_data", cpu_rdata, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic quiet();
        stall = '0; flush = 1'b0; cpu_ce = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
        cpu_sel = '0; cpu_wdata = '0; bus_rdata = '0; bus_ack = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #3;
    endtask

    task automatic req(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                       input logic [31:0] wdata);
        cpu_ce = 1'b1; cpu_we = we; cpu_addr = addr; cpu_sel = sel; cpu_wdata = wdata;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          delay;
    } load_vec_t;

    load_vec_t vecs[3];

    // ---------------- directed stimulus ----------------
    initial begin
        quiet();
        rst_n = 1'b0;
        #2;
        check1("rst_bus_req", bus_req, 1'b0);
        check32("rst_bus_addr", bus_addr, 32'd0);
        check1("rst_bus_timeout", bus_timeout, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        look();
        check1("idle_stallreq", stallreq, 1'b0);
        check32("idle_rdata", cpu_rdata, 32'd0);

        // Load, ack on the next cycle
        step(); req(1'b0, 32'h100, 4'hF, 32'd0); look();
        check1("t1_stall_req", stallreq, 1'b1);
        check1("t1_req_not_yet", bus_req, 1'b0);
        step(); cpu_ce = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
        exp_q.push_back(32'hDEADBEEF); look();
        check1("t1_bus_req", bus_req, 1'b1);
        check32("t1_rdata", cpu_rdata, 32'hDEADBEEF);
        check1("t1_stall_rel", stallreq, 1'b0);
        step(); quiet(); look();
        check1("t1_req_drop", bus_req, 1'b0);

        // Store, ack in the 4th BUSY cycle (also the timeout cycle: ack must win)
        step(); req(1'b1, 32'h204, 4'b0011, 32'h1234); look();
        check1("t2_stall0", stallreq, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(); look();
            check1("t2_stall_busy", stallreq, 1'b1);
            check32("t2_addr", bus_addr, 32'h204);
            check32("t2_wdata", bus_wdata, 32'h1234);
        end
        step(); cpu_ce = 1'b0; bus_ack = 1'b1; look();
        check1("t2_we", bus_we, 1'b1);
        check1("t2_stall_rel", stallreq, 1'b0);
        step(); quiet(); look();
        check1("t2_no_timeout", bus_timeout, 1'b0);
        check32("t2_sel_drop", 32'(bus_sel), 32'd0);

        // Load with stall held two cycles after ack
        step(); req(1'b0, 32'h300, 4'hF, 32'd0); look();
        step(); cpu_ce = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hA5A5A5A5; stall = 6'b000011;
        exp_q.push_back(32'hA5A5A5A5); look();
        check32("t3_rdata_ack", cpu_rdata, 32'hA5A5A5A5);
        for (int i = 0; i < 2; i++) begin
            step(); bus_ack = 1'b0; bus_rdata = 32'h11111111; req(1'b0, 32'h900, 4'hF, 32'd0); look();
            check32("t3_rdata_hold", cpu_rdata, 32'hA5A5A5A5);
            check1("t3_hold_stall", stallreq, 1'b0);
            check1("t3_hold_noreq", bus_req, 1'b0);
        end
        step(); cpu_ce = 1'b0; stall = '0; look();
        check32("t3_rdata_last", cpu_rdata, 32'hA5A5A5A5);
        step(); quiet(); look();
        check32("t3_back_idle", cpu_rdata, 32'd0);
        check1("t3_ce_ignored", bus_req, 1'b0);

        // Flush: in IDLE blocks the request; in BUSY cancels it; late ack ignored
        step(); req(1'b0, 32'h400, 4'hF, 32'd0); flush = 1'b1; look();
        check1("t4_flush_idle", stallreq, 1'b0);
        step(); flush = 1'b0; look();
        check1("t4_no_issue", bus_req, 1'b0);
        step(); look();
        check1("t4_busy_stall", stallreq, 1'b1);
        step(); flush = 1'b1; look();
        check1("t4_flush_stall", stallreq, 1'b0);
        step(); quiet(); bus_ack = 1'b1; bus_rdata = 32'hBAD0BAD0; look();
        check1("t4_req_drop", bus_req, 1'b0);
        check32("t4_late_ack", cpu_rdata, 32'd0);
        step(); quiet(); look();

        // Timeout after TMO BUSY cycles; stall held so the pulse lands in HOLD
        step(); req(1'b0, 32'h500, 4'hF, 32'd0); look();
        for (int i = 0; i < 3; i++) begin
            step(); look();
            check1("t5_wait_stall", stallreq, 1'b1);
        end
        step(); cpu_ce = 1'b0; stall = 6'b000001; look();
        check1("t5_tmo_stall", stallreq, 1'b0);
        check1("t5_tmo_req_still", bus_req, 1'b1);
        step(); cpu_ce = 1'b1; look();
        check1("t5_tmo_pulse", bus_timeout, 1'b1);
        check1("t5_req_drop", bus_req, 1'b0);
        check32("t5_rdata", cpu_rdata, 32'd0);
        step(); cpu_ce = 1'b0; stall = '0; look();
        check1("t5_pulse_end", bus_timeout, 1'b0);
        check1("t5_hold_noreq", bus_req, 1'b0);
        step(); quiet(); look();

        // Back-to-back loads with varying ack delay
        vecs[0] = '{addr: 32'h700, data: 32'h01234567, delay: 0};
        vecs[1] = '{addr: 32'h704, data: 32'h89ABCDEF, delay: 2};
        vecs[2] = '{addr: 32'h708, data: 32'h0F0F0F0F, delay: 1};
        foreach (vecs[k]) begin
            step(); bus_ack = 1'b0; req(1'b0, vecs[k].addr, 4'hF, 32'd0);
            for (int d = 0; d < vecs[k].delay; d++) step();
            step(); cpu_ce = 1'b0; bus_ack = 1'b1; bus_rdata = vecs[k].data;
            exp_q.push_back(vecs[k].data);
        end
        step(); quiet(); look();

        // Alignment handling
`ifdef DBUS_ALIGN_CHECK_EN
        step(); req(1'b0, 32'h102, 4'hF, 32'd0); look();
        check1("t7_word_mis", misalign_exc, 1'b1);
        check1("t7_word_nostall", stallreq, 1'b0);
        step(); req(1'b1, 32'h101, 4'b0011, 32'h77); look();
        check1("t7_half_mis", misalign_exc, 1'b1);
        check1("t7_noreq", bus_req, 1'b0);
        step(); quiet(); look();
        check1("t7_noreq2", bus_req, 1'b0);
        step(); req(1'b1, 32'h102, 4'b1100, 32'h5A5A0000); look();
        check1("t7_half_ok", misalign_exc, 1'b0);
        check1("t7_half_stall", stallreq, 1'b1);
        step(); cpu_ce = 1'b0; bus_ack = 1'b1; look();
        check1("t7_half_req", bus_req, 1'b1);
        check32("t7_half_addr", bus_addr, 32'h102);
`else
        step(); req(1'b1, 32'h102, 4'hF, 32'h55AA); look();
        check1("t7_unaligned_stall", stallreq, 1'b1);
        step(); cpu_ce = 1'b0; bus_ack = 1'b1; look();
        check1("t7_unaligned_req", bus_req, 1'b1);
        check32("t7_unaligned_addr", bus_addr, 32'h102);
`endif
        step(); quiet(); look();

        // Asynchronous reset mid-BUSY, then a late ack
        step(); req(1'b1, 32'h600, 4'hF, 32'hCAFEF00D); look();
        step(); look();
        check1("t6_busy", bus_req, 1'b1);
        rst_n = 1'b0; cpu_ce = 1'b0;
        #1;
        check1("t6_rst_req", bus_req, 1'b0);
        check1("t6_rst_we", bus_we, 1'b0);
        check32("t6_rst_addr", bus_addr, 32'd0);
        check32("t6_rst_sel", 32'(bus_sel), 32'd0);
        check32("t6_rst_wdata", bus_wdata, 32'd0);
        check1("t6_rst_stall", stallreq, 1'b0);
        step();
        step(); rst_n = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h77777777; look();
        check1("t6_late_req", bus_req, 1'b0);
        check32("t6_late_rdata", cpu_rdata, 32'd0);
        step(); quiet(); look();
        check1("t6_still_idle", bus_req, 1'b0);
        step(); look();

        check32("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_dbus_if.md
Name: mem_dbus_if

Overview:
- Data-bus master for the MEM stage; the consuming end of the EX/MEM latch outputs (memory address, store data, access enables).
- Converts one pipeline load/store request into a request/acknowledge transaction on the external data bus.
- Raises stallreq while the transaction is outstanding.
- Buffers read data until the pipeline releases its stall, so the MEM stage sees the result exactly once.

Parameters:
- TIMEOUT_CYC, 255: bus cycles to wait for bus_ack before abandoning a transaction; 0 disables the timeout.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset
- stall  input  6  pipeline stall vector; any bit set means the pipeline is held
- flush  input  1  pipeline flush; cancels the current request
- cpu_ce  input  1  MEM-stage access enable
- cpu_we  input  1  1=store, 0=load
- cpu_addr  input  32  byte address
- cpu_sel  input  4  byte lane enables
- cpu_wdata  input  32  store data
- cpu_rdata  output  32  load data to MEM stage
- stallreq  output  1  stall request to the pipeline controller
- bus_req  output  1  bus strobe/cycle
- bus_we  output  1  bus write enable
- bus_addr  output  32  bus address
- bus_sel  output  4  bus byte lanes
- bus_wdata  output  32  bus write data
- bus_rdata  input  32  bus read data
- bus_ack  input  1  bus acknowledge, one-cycle pulse
- bus_timeout  output  1  one-cycle pulse on abandoned transaction

Behaviour:
- Interface: one clock domain, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_sel=0, bus_wdata=0; rd_buf=0; timeout counter=0; bus_timeout=0.
- bus_* outputs and bus_timeout are registered. cpu_rdata and stallreq are combinational from state, bus_ack and rd_buf.
- IDLE:
  - If cpu_ce=1 and flush=0: stallreq=1 in the same cycle; register bus_req=1 and cpu_we/addr/sel/wdata onto bus_*; clear rd_buf and counter; next state BUSY.
  - Otherwise stallreq=0, cpu_rdata=0.
- BUSY, bus_ack=1:
  - Deassert bus_req, bus_we, bus_sel.
  - For a load, capture rd_buf=bus_rdata and drive cpu_rdata=bus_rdata combinationally this cycle.
  - stallreq=0.
  - Next state HOLD if stall!=0, else IDLE.
  - Minimum load latency: request in cycle N, ack in N+1, data and stall release in N+1.
- BUSY, bus_ack=0: stallreq=1; counter increments.
- BUSY, flush=1: takes priority over ack. Deassert all bus outputs, stallreq=0, next state IDLE, rd_buf unchanged.
- BUSY timeout (TIMEOUT_CYC!=0 and counter reaches TIMEOUT_CYC-1 without ack):
  - Deassert bus outputs; pulse bus_timeout for 1 cycle.
  - rd_buf=0; stallreq=0.
  - Next state HOLD if stall!=0, else IDLE.
- HOLD: stallreq=0, cpu_rdata=rd_buf. When stall==0, next state IDLE. A new cpu_ce is ignored until back in IDLE.
- bus_req never stays high after ack or timeout; at most one outstanding transaction.
- Bus outputs are held stable while BUSY.
- Reset asserted mid-transaction returns immediately to reset values; a late ack after reset is ignored.

Optional Feature:
- Macro: DBUS_ALIGN_CHECK_EN.
- Defined:
  - Adds output misalign_exc (1 bit, combinational).
  - In IDLE with cpu_ce=1, checks alignment: cpu_sel==4'b1111 with addr[1:0]!=0, or cpu_sel in {0011,1100} with addr[0]!=0.
  - On misalignment: misalign_exc=1, no bus transaction, stallreq=0, state stays IDLE.
- Undefined: port absent; no alignment check; every access is issued.

Test Plan:
- Load, ack one cycle after request, stall=0: addr=0x100, bus_rdata=0xDEADBEEF -> bus_req high 1 cycle, cpu_rdata=0xDEADBEEF in ack cycle, stallreq 1 then 0.
- Store, ack delayed 3 cycles: addr=0x204, sel=4'b0011, wdata=0x1234 -> bus_we=1, bus_addr/sel/wdata stable for 4 cycles, stallreq=1 for those 4 cycles.
- Load with stall=6'b000011 held 2 cycles after ack, bus_rdata=0xA5A5A5A5 -> state HOLD, cpu_rdata=0xA5A5A5A5 throughout, returns to IDLE when stall=0.
- flush asserted while BUSY (no ack) -> bus_req drops next edge, stallreq=0, late ack ignored, IDLE.
- TIMEOUT_CYC=4, no ack -> bus_timeout pulses after 4 BUSY cycles, bus_req=0, cpu_rdata=0.
- rst_n low mid-BUSY -> all bus outputs 0 asynchronously; with DBUS_ALIGN_CHECK_EN, word access at 0x102 -> misalign_exc=1, bus_req stays 0.
